// File: rtl/satatx_crc.sv
// satatx_crc: forwards FIS data words with one cycle of latency and appends
// the SATA CRC-32 as one extra word, moving TLAST onto that word.
module satatx_crc #(
  parameter logic [31:0] P_CRC_INIT   = 32'h5232_5032,
  parameter logic [31:0] P_POLY       = 32'h04c1_1db7,
  parameter logic        OPT_LOWPOWER = 1'b0
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST
);

  typedef enum logic [0:0] {
    S_DATA = 1'b0,
    S_CRC  = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        m_valid_q;
  logic [31:0] m_data_q;
  logic        m_last_q;
  logic        out_free;
  logic        s_accept;

  // MSB-first, non-reflected CRC over a full 32-bit word in a single cycle.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? P_POLY : 32'h0000_0000);
    end
    return r;
  endfunction

  // Valid/ready: a beat transfers on any rising edge where VALID and READY are
  // both high; once raised, master VALID/DATA/LAST hold until that transfer.
  assign out_free      = !m_valid_q || M_AXIS_TREADY;
  assign S_AXIS_TREADY = out_free && (state_q == S_DATA);
  assign s_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign crc_d         = crc_step(crc_q, S_AXIS_TDATA);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= S_DATA;
      crc_q     <= P_CRC_INIT;
      m_valid_q <= 1'b0;
      if (OPT_LOWPOWER) begin
        m_data_q <= 32'h0000_0000;
        m_last_q <= 1'b0;
      end
    end else begin
      case (state_q)
        S_DATA: begin
          if (s_accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= S_AXIS_TDATA;
            m_last_q  <= 1'b0;
            crc_q     <= crc_d;
            if (S_AXIS_TLAST) state_q <= S_CRC;
          end else if (M_AXIS_TREADY) begin
            m_valid_q <= 1'b0;
            if (OPT_LOWPOWER) begin
              m_data_q <= 32'h0000_0000;
              m_last_q <= 1'b0;
            end
          end
        end
        S_CRC: begin
          // The CRC word is never folded back into the running CRC.
          if (out_free) begin
            m_valid_q <= 1'b1;
            m_data_q  <= crc_q;
            m_last_q  <= 1'b1;
            crc_q     <= P_CRC_INIT;
            state_q   <= S_DATA;
          end
        end
        default: begin
          state_q   <= S_DATA;
          crc_q     <= P_CRC_INIT;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TLAST  = m_last_q;

endmodule

// File: tb/tb_satatx_crc.sv
// Bench for satatx_crc: directed scenario tasks plus a negedge scoreboard that
// tracks every input/output beat against a bit-serial CRC model.
module tb_satatx_crc;

  localparam logic [31:0] INIT = 32'h5232_5032;
  localparam logic [31:0] POLY = 32'h04c1_1db7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        s_ready;
  logic        m_valid, m_last;
  logic [31:0] m_data;
  logic        m_ready = 1'b1;

  logic        s2_valid = 1'b0, s2_last = 1'b0;
  logic [31:0] s2_data = 32'h0;
  logic        s2_ready;
  logic        m2_valid, m2_last;
  logic [31:0] m2_data;
  logic        m2_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_pct = 100;

  logic [32:0] exp_q[$];
  logic [31:0] cur_crc, out_crc, last_crc, st_data;
  logic        st_last, stalled;
  int          beats = 0, rdy_low = 0, tlast_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

  satatx_crc #(.P_CRC_INIT(INIT), .P_POLY(POLY), .OPT_LOWPOWER(1'b1)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data), .M_AXIS_TLAST(m_last)
  );

  satatx_crc #(.P_CRC_INIT(32'h0000_0000), .P_POLY(POLY), .OPT_LOWPOWER(1'b0)) dut_seed (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXIS_TVALID(s2_valid), .S_AXIS_TREADY(s2_ready), .S_AXIS_TDATA(s2_data), .S_AXIS_TLAST(s2_last),
    .M_AXIS_TVALID(m2_valid), .M_AXIS_TREADY(m2_ready), .M_AXIS_TDATA(m2_data), .M_AXIS_TLAST(m2_last)
  );

  // ---------------- clock / reset / downstream ready ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_ready = ($urandom_range(99) < rdy_pct);
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Shift-left Galois form, one data bit at a time.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic        msb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      msb = r[31];
      r   = r << 1;
      if (msb != d[i]) r = r ^ POLY;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      cur_crc = INIT;
      out_crc = INIT;
      stalled = 1'b0;
    end else begin
      cyc++;
      if (s_valid && s_ready) begin
        cur_crc = model_crc(cur_crc, s_data);
        exp_q.push_back({1'b0, s_data});
        if (s_last) begin
          exp_q.push_back({1'b1, cur_crc});
          cur_crc = INIT;
        end
      end
      if (!s_ready) rdy_low++;
      if (stalled) begin
        n_cmp++;
        if (!m_valid || m_data !== st_data || m_last !== st_last) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   m_valid, m_data, m_last, st_data, st_last);
        end
      end
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_extra: got d=%h l=%b expected no output word", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            n_err++;
            $display("FAIL out_word: got l=%b d=%h expected l=%b d=%h", m_last, m_data, e[32], e[31:0]);
          end
        end
        out_crc = model_crc(out_crc, m_data);
        beats++;
        if (beats == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (m_last) begin
          tlast_cnt++;
          last_crc = m_data;
          n_cmp++;
          if (out_crc !== 32'h0) begin
            n_err++;
            $display("FAIL residue: got %h expected 00000000", out_crc);
          end
          out_crc = INIT;
        end
      end
      if (!m_valid) begin
        n_cmp++;
        if (m_data !== 32'h0 || m_last !== 1'b0) begin
          n_err++;
          $display("FAIL lowpower_idle: got d=%h l=%b expected d=00000000 l=0", m_data, m_last);
        end
      end
      stalled = m_valid && !m_ready;
      st_data = m_data;
      st_last = m_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [31:0] d, input logic l, input int pct);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = d;
      s_last  = l;
      @(negedge clk);
      done = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got no handshake expected handshake within 2000 cycles");
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int vpct, input logic [31:0] base, output logic [31:0] crc);
    logic [31:0] d;
    crc = INIT;
    for (int k = 0; k < n; k++) begin
      d   = base ^ (32'(k) * 32'h9e37_79b9);
      crc = model_crc(crc, d);
      drive_word(d, (k == n - 1), vpct);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending words expected 0", exp_q.size());
    end
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got m_valid=%b expected 0", name, m_valid);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_valid, s_ready, m_last, m_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_main: got v=%b rdy=%b l=%b d=%h expected v=0 rdy=1 l=0 d=00000000",
               m_valid, s_ready, m_last, m_data);
    end
    n_cmp++;
    if ({m2_valid, s2_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_seed: got v=%b rdy=%b expected v=0 rdy=1", m2_valid, s2_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_seed();
    s2_valid = 1'b1; s2_data = 32'h0000_0001; s2_last = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s2_ready !== 1'b1) begin
      n_err++; $display("FAIL seed_ready: got %b expected 1", s2_ready);
    end
    @(posedge clk); #1;
    s2_valid = 1'b0; s2_data = 32'h0; s2_last = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m2_valid, m2_last, m2_data, s2_ready} !== {1'b1, 1'b0, 32'h0000_0001, 1'b0}) begin
      n_err++;
      $display("FAIL seed_data: got v=%b l=%b d=%h rdy=%b expected v=1 l=0 d=00000001 rdy=0",
               m2_valid, m2_last, m2_data, s2_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({m2_valid, m2_last, m2_data} !== {1'b1, 1'b1, 32'h04c1_1db7}) begin
      n_err++;
      $display("FAIL seed_crc: got v=%b l=%b d=%h expected v=1 l=1 d=04c11db7", m2_valid, m2_last, m2_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (m2_valid !== 1'b0) begin
      n_err++; $display("FAIL seed_idle: got v=%b expected 0", m2_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_residue();
    logic [31:0] e;
    rdy_pct   = 100;
    tlast_cnt = 0;
    for (int p = 0; p < 20; p++) send_pkt($urandom_range(1, 64), 100, $urandom, e);
    drain();
    n_cmp++;
    if (tlast_cnt != 20) begin
      n_err++; $display("FAIL residue_pkts: got %0d expected 20", tlast_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_alone, e_tmp, alone;
    rdy_pct = 100;
    send_pkt(3, 100, 32'h1234_5678, e_alone);
    drain();
    alone = last_crc;
    n_cmp++;
    if (alone !== e_alone) begin
      n_err++; $display("FAIL b2b_alone: got %h expected %h", alone, e_alone);
    end
    beats = 0; rdy_low = 0;
    send_pkt(3, 100, 32'hcafe_0000, e_tmp);
    send_pkt(3, 100, 32'h1234_5678, e_tmp);
    drain();
    n_cmp++;
    if (beats != 8 || (last_cyc - first_cyc + 1) != 8) begin
      n_err++;
      $display("FAIL b2b_beats: got %0d beats over %0d cycles expected 8 over 8", beats, last_cyc - first_cyc + 1);
    end
    n_cmp++;
    if (rdy_low != 2) begin
      n_err++; $display("FAIL b2b_bubbles: got %0d expected 2", rdy_low);
    end
    n_cmp++;
    if (last_crc !== alone) begin
      n_err++; $display("FAIL b2b_crc: got %h expected %h", last_crc, alone);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    rdy_pct = 100;
    drive_word(32'h1111_0001, 1'b0, 100);
    drive_word(32'h1111_0002, 1'b0, 100);
    pulse_reset("rst_mid_valid");
    send_pkt(4, 100, 32'h2222_0000, e);
    drain();
    n_cmp++;
    if (last_crc !== e) begin
      n_err++; $display("FAIL rst_mid_crc: got %h expected %h", last_crc, e);
    end
    send_pkt(1, 100, 32'h3333_0000, e);
    @(posedge clk); #1;
    rdy_pct = 0; m_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    pulse_reset("rst_crcstall_valid");
    rdy_pct = 100; m_ready = 1'b1;
    send_pkt(3, 100, 32'h4444_0000, e);
    drain();
    n_cmp++;
    if (last_crc !== e) begin
      n_err++; $display("FAIL rst_crcstall_crc: got %h expected %h", last_crc, e);
    end
    rdy_pct = 0; m_ready = 1'b0;
    send_pkt(1, 100, 32'h5555_0000, e);
    repeat (2) begin @(posedge clk); #1; end
    pulse_reset("rst_scrc_valid");
    rdy_pct = 100; m_ready = 1'b1;
    send_pkt(2, 100, 32'h6666_0000, e);
    drain();
    n_cmp++;
    if (last_crc !== e) begin
      n_err++; $display("FAIL rst_scrc_crc: got %h expected %h", last_crc, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    rdy_pct   = 50;
    tlast_cnt = 0;
    for (int p = 0; p < 1000; p++) send_pkt($urandom_range(1, 6), 50, $urandom, e);
    rdy_pct = 100;
    drain();
    n_cmp++;
    if (tlast_cnt != 1000) begin
      n_err++; $display("FAIL bp_tlast: got %0d expected 1000", tlast_cnt);
    end
  endtask

  task automatic test_lowpower();
    logic [31:0] e;
    rdy_pct = 30;
    send_pkt(5, 100, 32'h7777_0000, e);
    rdy_pct = 100;
    drain();
    @(negedge clk);
    n_cmp++;
    if ({m_valid, m_last, m_data} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL lowpower_final: got v=%b l=%b d=%h expected v=0 l=0 d=00000000", m_valid, m_last, m_data);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_seed();
    test_residue();
    test_back_to_back();
    test_reset_mid();
    test_lowpower();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
